// File: rtl/specialcases.sv
// Shared single-precision types, result classification and scheduler state encoding
// for the shared multiplier.
package specialcases;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp;

  // zero is the first enumerator so that its encoding is all-zeros.
  typedef enum logic [2:0] {
    zero,
    nan,
    positive_infinity,
    negative_infinity,
    overflow,
    underflow,
    normalizedNumber
  } SpecialCases;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam int unsigned FP_BIAS = 127;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } sched_state_t;

endpackage

// File: rtl/fp_mul_scheduler_multiplication.sv
// Combinational single-precision mantissa multiply with round-to-nearest-even.
// Special operands are not handled here; the scheduler substitutes those results.
module Multiplication
  import specialcases::*;
(
  input  fp    a,
  input  fp    b,
  output fp    result,
  output logic product_msb
);

  logic [47:0] product;
  logic [22:0] mant_trunc;
  logic        guard;
  logic        sticky;
  logic        lsb;
  logic        round_up;
  logic [7:0]  exp_res;

  always_comb begin
    product     = 48'({1'b1, a.mant}) * 48'({1'b1, b.mant});
    product_msb = product[47];
    if (product[47]) begin
      mant_trunc = product[46:24];
      guard      = product[23];
      sticky     = |product[22:0];
      lsb        = product[24];
    end else begin
      mant_trunc = product[45:23];
      guard      = product[22];
      sticky     = |product[21:0];
      lsb        = product[23];
    end
    round_up = guard & (sticky | lsb);
    // A carry out of the rounded mantissa is dropped, the exponent is not bumped.
    exp_res  = a.exp + b.exp - 8'(FP_BIAS) + 8'(product[47]);
    result   = '{sign: a.sign ^ b.sign, exp: exp_res, mant: mant_trunc + 23'(round_up)};
  end

endmodule

// File: rtl/fp_mul_scheduler_rr_arbiter.sv
// Round-robin priority select: first asserted request at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    logic        found;
    int unsigned idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(pointer) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one multicycle single-precision multiplier between NUM_REQ requesters using
// round-robin arbitration; special operands are classified and substituted here.
module fp_mul_scheduler
  import specialcases::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_result,
  output logic [ID_W-1:0]      rsp_id,
  output SpecialCases          rsp_status
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  sched_state_t    state_q;
  logic [ID_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  fp               a_q;
  fp               b_q;
  logic [ID_W-1:0] id_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_result_q;
  logic [ID_W-1:0] rsp_id_q;
  SpecialCases     rsp_status_q;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  fp                  sel_a;
  fp                  sel_b;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .pointer   (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = (state_q == IDLE && !rst) ? grant : '0;
  assign accept    = |req_ready;
  assign sel_a     = req_a[32'(grant_idx)*32 +: 32];
  assign sel_b     = req_b[32'(grant_idx)*32 +: 32];

  fp    mul_result;
  logic prod_msb;

  Multiplication u_mul (
    .a           (a_q),
    .b           (b_q),
    .result      (mul_result),
    .product_msb (prod_msb)
  );

  logic        sign;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [9:0]  e_raw;
  logic [31:0] cls_result;
  SpecialCases cls_status;

  always_comb begin
    sign   = a_q.sign ^ b_q.sign;
    a_nan  = (a_q.exp == 8'hFF) && (a_q.mant != '0);
    b_nan  = (b_q.exp == 8'hFF) && (b_q.mant != '0);
    a_inf  = (a_q.exp == 8'hFF) && (a_q.mant == '0);
    b_inf  = (b_q.exp == 8'hFF) && (b_q.mant == '0);
    a_zero = (a_q.exp == 8'h00);
    b_zero = (b_q.exp == 8'h00);
    // Two's-complement biased exponent; bit 9 set means the sum went negative.
    e_raw  = {2'b0, a_q.exp} + {2'b0, b_q.exp} + {9'b0, prod_msb} - 10'(FP_BIAS);
    cls_result = mul_result;
    cls_status = normalizedNumber;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      cls_result = FP_QNAN;
      cls_status = nan;
    end else if (a_inf || b_inf) begin
      cls_result = {sign, 8'hFF, 23'h0};
      cls_status = sign ? negative_infinity : positive_infinity;
    end else if (a_zero || b_zero) begin
      cls_result = {sign, 31'h0};
      cls_status = zero;
    end else if (!e_raw[9] && (e_raw >= 10'd255)) begin
      cls_result = {sign, 8'hFF, 23'h0};
      cls_status = overflow;
    end else if (e_raw[9] || (e_raw == 10'd0)) begin
      cls_result = {sign, 31'h0};
      cls_status = underflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_id_q     <= '0;
      rsp_status_q <= zero;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= grant_idx;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            rsp_result_q <= cls_result;
            rsp_id_q     <= id_q;
            rsp_status_q <= cls_status;
            rsp_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_status = rsp_status_q;

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_fp_mul_scheduler;
  import specialcases::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned LATENCY = 1;
  localparam int unsigned ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_result;
  logic [ID_W-1:0]       rsp_id;
  SpecialCases           rsp_status;

  fp_mul_scheduler #(
    .NUM_REQ (NUM_REQ),
    .LATENCY (LATENCY),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_status (rsp_status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     result;
    logic [ID_W-1:0] id;
    SpecialCases     status;
  } exp_t;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    SpecialCases st;
  } vec_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic rsp_valid_prev = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: accept timestamps, response latency and scoreboard compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (|(req_ready & req_valid)) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        acc_q.push_back(cyc);
      end
      if (rsp_valid && !rsp_valid_prev) begin
        if (acc_q.size() == 0) chk("rsp_without_accept", 32'(rsp_valid), 32'd0);
        else chk("latency", 32'(cyc - acc_q.pop_front()), 32'(LATENCY + 1));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_result", rsp_result, e.result);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_status", 32'(rsp_status), 32'(e.status));
        end
      end
    end
    rsp_valid_prev = rsp_valid;
  end

  task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
  endtask

  task automatic push(input logic [31:0] res, input int id, input SpecialCases st);
    exp_t e;
    e.result = res;
    e.id     = ID_W'(id);
    e.status = st;
    exp_q.push_back(e);
  endtask

  // Raise valid on the masked requesters and drop each one right after its accept.
  task automatic run_mask(input logic [NUM_REQ-1:0] mask);
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] acc;
    int budget;
    pending   = mask;
    budget    = 200;
    req_valid = req_valid | mask;
    while (pending != '0 && budget > 0) begin
      @(negedge clk);
      acc = req_ready & req_valid & pending;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~acc;
      pending   = pending & ~acc;
      budget--;
    end
    if (pending != '0) chk("accept_timeout", 32'(pending), 32'd0);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8] = '{
    '{2, 32'h40000000, 32'h40400000, 32'h40C00000, normalizedNumber},
    '{1, 32'h7F800000, 32'h00000000, 32'h7FC00000, nan},
    '{3, 32'hFF800000, 32'h40000000, 32'hFF800000, negative_infinity},
    '{0, 32'h7F000000, 32'h7F000000, 32'h7F800000, overflow},
    '{1, 32'h00800000, 32'h00800000, 32'h00000000, underflow},
    '{2, 32'hFFC00000, 32'h3F800000, 32'h7FC00000, nan},
    '{0, 32'h80000000, 32'h40000000, 32'h80000000, zero},
    '{3, 32'h00000001, 32'h3F800000, 32'h00000000, zero}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_status", 32'(rsp_status), 32'(zero));
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All requesters contend: strict rotation from pointer 0, one accept per 3 cycles.
    for (int i = 0; i < 4; i++) set_op(i, 32'h3F800000, 32'h3F800000);
    push(32'h3F800000, 0, normalizedNumber);
    push(32'h3F800000, 1, normalizedNumber);
    push(32'h3F800000, 2, normalizedNumber);
    push(32'h3F800000, 3, normalizedNumber);
    push(32'h3F800000, 0, normalizedNumber);
    begin
      int count;
      int last;
      int budget;
      count     = 0;
      last      = 0;
      budget    = 100;
      req_valid = 4'hF;
      while (count < 5 && budget > 0) begin
        @(negedge clk);
        if (|(req_ready & req_valid)) begin
          if (count > 0) chk("accept_interval", 32'(cyc - last), 32'd3);
          last = cyc;
          count++;
        end
        @(posedge clk);
        #1;
        if (count == 5) req_valid = '0;
        budget--;
      end
      if (count != 5) chk("rotation_timeout", 32'(count), 32'd5);
      req_valid = '0;
    end
    drain();

    // Directed single operations, normal and special-case operands.
    for (int i = 0; i < 8; i++) begin
      set_op(vecs[i].r, vecs[i].a, vecs[i].b);
      push(vecs[i].res, vecs[i].r, vecs[i].st);
      run_mask(NUM_REQ'(1) << vecs[i].r);
      drain();
    end

    // Backpressure: response held in DONE while requester 3 waits.
    rsp_ready = 1'b0;
    set_op(0, 32'h40000000, 32'h40000000);
    push(32'h40800000, 0, normalizedNumber);
    set_op(3, 32'hC0000000, 32'h40400000);
    push(32'hC0C00000, 3, normalizedNumber);
    run_mask(4'b0001);
    req_valid[3] = 1'b1;
    begin
      int b;
      b = 0;
      @(negedge clk);
      while (!rsp_valid && b < 20) begin
        @(negedge clk);
        b++;
      end
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_result", rsp_result, 32'h40800000);
      chk("stall_id", 32'(rsp_id), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pending_accept", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    drain();

    // Move the pointer off zero, then abort an op mid-flight with reset.
    set_op(1, 32'h3F800000, 32'h40000000);
    push(32'h40000000, 1, normalizedNumber);
    run_mask(4'b0010);
    drain();
    set_op(2, 32'h40000000, 32'h40000000);
    push(32'h40800000, 2, normalizedNumber);
    run_mask(4'b0100);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_q.delete();
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rsp_result", rsp_result, 32'h0);
    chk("abort_rsp_id", 32'(rsp_id), 32'd0);
    chk("abort_rsp_status", 32'(rsp_status), 32'(zero));
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    set_op(0, 32'h3F800000, 32'h3F800000);
    set_op(1, 32'h40400000, 32'h40400000);
    set_op(3, 32'hC0400000, 32'h40000000);
    push(32'h3F800000, 0, normalizedNumber);
    push(32'h41100000, 1, normalizedNumber);
    push(32'hC0C00000, 3, normalizedNumber);
    run_mask(4'b1011);
    drain();
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
